// File: rtl/iter_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   md_op_e    : 3-bit operation code (encodings 5..7 behave as MD_MUL)
//   md_state_e : sequencer states
//   is_div / is_signed_x / is_signed_y : operation decode helpers
package md_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_DIV    = 3'd3,
    MD_DIVU   = 3'd4
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIXUP,
    ST_DONE
  } md_state_e;

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_x(input logic [OP_W-1:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV);
  endfunction

  function automatic logic is_signed_y(input logic [OP_W-1:0] op);
    return (op == MD_MULH) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/iter_muldiv_if.sv
// Request/response bundle of the iterative multiply/divide unit.
//   master : requester side (drives in_valid/op/x/y and out_ready)
//   slave  : unit side (drives in_ready, out_valid, results, div_zero)
interface iter_muldiv_if
  import md_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op;
  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  y;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result_lo;
  logic [WIDTH-1:0]  result_hi;
  logic              div_zero;

  modport master (
    output in_valid, op, x, y, out_ready,
    input  in_ready, out_valid, result_lo, result_hi, div_zero
  );

  modport slave (
    input  in_valid, op, x, y, out_ready,
    output in_ready, out_valid, result_lo, result_hi, div_zero
  );
endinterface

// File: rtl/iter_muldiv_core_step.sv
// One iteration of the magnitude datapath, purely combinational.
//   acc     : {hi, lo} working register (product / remainder:quotient)
//   opb     : multiplicand (multiply) or divisor (divide), unsigned
//   is_div  : select restoring-divide step instead of shift-add step
//   acc_nxt : register value after this iteration
module md_core_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opb,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;

  assign hi = acc[2*WIDTH-1:WIDTH];
  assign lo = acc[WIDTH-1:0];

  always_comb begin
    // Multiply: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole register right; the carry becomes the MSB.
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    // Divide: shift the next dividend bit into the remainder and trial
    // subtract; a borrow out of bit WIDTH means the trial failed.
    sh   = {hi, lo[WIDTH-1]};
    diff = sh - {1'b0, opb};
    if (is_div) begin
      if (diff[WIDTH])
        acc_nxt = {sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
      else
        acc_nxt = {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {sum, lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative multiply/divide unit: one bit per cycle, shift-add multiply and
// restoring divide on operand magnitudes, sign fix-up in a final cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous abort, returns to idle with no result
//   bus        : request (in_valid/in_ready/op/x/y) and response
//                (out_valid/out_ready/result_lo/result_hi/div_zero)
module iter_muldiv
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  iter_muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opb;
  logic               div_q;
  logic               neg_lo;
  logic               neg_hi;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   res_lo_q;
  logic [WIDTH-1:0]   res_hi_q;

  logic               req_div;
  logic               sgn_x;
  logic               sgn_y;
  logic [WIDTH-1:0]   mag_x;
  logic [WIDTH-1:0]   mag_y;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return '0 - v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return '0 - v;
  endfunction

  // Magnitude of a two's complement value; the most negative value maps to
  // 2^(WIDTH-1), which is still representable as an unsigned WIDTH-bit value.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                           input logic              neg);
    return neg ? neg_w(v) : v;
  endfunction

  assign req_div = is_div(bus.op);
  assign sgn_x   = is_signed_x(bus.op) & bus.x[WIDTH-1];
  assign sgn_y   = is_signed_y(bus.op) & bus.y[WIDTH-1];
  assign mag_x   = mag(bus.x, sgn_x);
  assign mag_y   = mag(bus.y, sgn_y);

  md_core_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .opb     (opb),
    .is_div  (div_q),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      acc         <= '0;
      opb         <= '0;
      div_q       <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
    end else if (flush) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            div_zero_q <= 1'b0;
            cnt        <= CNT_INIT;
            div_q      <= req_div;
            // Multiply iterates over the multiplier in the low half;
            // divide shifts the dividend out of the low half.
            acc        <= {{WIDTH{1'b0}}, req_div ? mag_x : mag_y};
            opb        <= req_div ? mag_y : mag_x;
            // neg_lo: product / quotient sign, neg_hi: remainder sign.
            neg_lo     <= sgn_x ^ sgn_y;
            neg_hi     <= sgn_x;
            if (req_div && (bus.y == '0)) begin
              res_lo_q    <= '1;
              res_hi_q    <= bus.x;
              div_zero_q  <= 1'b1;
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc <= acc_nxt;
          if (cnt == '0)
            state <= ST_FIXUP;
          else
            cnt <= cnt - CNT_W'(1);
        end
        ST_FIXUP: begin
          if (div_q) begin
            res_lo_q <= neg_lo ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
            res_hi_q <= neg_hi ? neg_w(acc[2*WIDTH-1:WIDTH])
                               : acc[2*WIDTH-1:WIDTH];
          end else begin
            {res_hi_q, res_lo_q} <= neg_lo ? neg_2w(acc) : acc;
          end
          out_valid_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Self-checking bench for iter_muldiv (WIDTH=32): directed literal cases,
// handshake/flush/reset cases and randomized operations checked against a
// plain-arithmetic reference model on every cycle.
module tb_iter_muldiv;
  import md_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  iter_muldiv_if #(.WIDTH(W)) bus ();

  iter_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  bit   head_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {div_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [2*W:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [63:0] ea, eb, p;
    longint sa, sb, qq, rr;
    if (o == 3'd3 || o == 3'd4) begin
      if (b == 0) return {1'b1, a, {W{1'b1}}};
      if (o == 3'd3) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        qq = sa / sb;
        rr = sa % sb;
        return {1'b0, rr[W-1:0], qq[W-1:0]};
      end
      return {1'b0, a % b, a / b};
    end
    ea = (o == 3'd1 || o == 3'd2) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = (o == 3'd1) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = ea * eb;
    return {1'b0, p};
  endfunction

  // Compare process: every cycle, check outputs against the model queue.
  always @(negedge clk) begin
    logic [2*W:0] m;
    exp_t e;
    if (!rst_n) begin
      q.delete();
      head_seen = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          if (!head_seen) begin
            chk("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
            head_seen = 1'b1;
          end
          chk("result_lo", 64'(bus.result_lo), 64'(q[0].lo));
          chk("result_hi", 64'(bus.result_hi), 64'(q[0].hi));
          chk("div_zero", 64'(bus.div_zero), 64'(q[0].dz));
          chk("in_ready_done", 64'(bus.in_ready), 64'd0);
        end
      end else if (q.size() != 0) begin
        if (!head_seen && (cyc - q[0].acc + 1) >= q[0].lat) begin
          chk("late_out_valid", 64'(bus.out_valid), 64'd1);
          head_seen = 1'b1;
        end
        chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
      end else begin
        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
      end
      if (flush) begin
        q.delete();
        head_seen = 1'b0;
      end else begin
        if (bus.out_valid && bus.out_ready && q.size() != 0) begin
          void'(q.pop_front());
          head_seen = 1'b0;
        end
        if (bus.in_valid && bus.in_ready) begin
          m = model(bus.op, bus.x, bus.y);
          e.lo  = m[W-1:0];
          e.hi  = m[2*W-1:W];
          e.dz  = m[2*W];
          e.lat = m[2*W] ? 1 : W + 2;
          e.acc = cyc + 1;
          q.push_back(e);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    while (!bus.in_ready && t < 200) begin
      @(posedge clk); #2; t++;
    end
    if (!bus.in_ready) begin
      chk("issue_timeout", 64'(bus.in_ready), 64'd1);
      return;
    end
    bus.op = o; bus.x = a; bus.y = b; bus.in_valid = 1'b1;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!bus.out_valid && t < 100) begin
      @(posedge clk); #2; t++;
    end
    if (!bus.out_valid) chk("valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic wait_done();
    int t = 0;
    while ((q.size() != 0 || !bus.in_ready) && t < 200) begin
      @(posedge clk); #2; t++;
    end
    if (q.size() != 0) chk("done_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic lit(input string name, input logic [2:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] lo, input logic [W-1:0] hi,
                     input logic dz);
    chk({name, "_model"}, 64'(model(o, a, b)), 64'({dz, hi, lo}));
    issue(o, a, b);
    wait_done();
    chk({name, "_lo"}, 64'(bus.result_lo), 64'(lo));
    chk({name, "_hi"}, 64'(bus.result_hi), 64'(hi));
    chk({name, "_dz"}, 64'(bus.div_zero), 64'(dz));
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.op = '0; bus.x = '0; bus.y = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_lo", 64'(bus.result_lo), 64'd0);
    chk("rst_hi", 64'(bus.result_hi), 64'd0);
    chk("rst_dz", 64'(bus.div_zero), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    lit("mul", MD_MUL, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0);
    lit("mulh", MD_MULH, -32'sd3, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0);
    lit("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 1'b0);
    lit("div", MD_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    lit("divu", MD_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    lit("divu0", MD_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b1);
    lit("mul_clr_dz", MD_MUL, 32'd3, 32'd5, 32'd15, 32'd0, 1'b0);
    lit("div0_s", MD_DIV, -32'sd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    lit("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    lit("rsvd5", 3'd5, 32'd9, 32'd9, 32'd81, 32'd0, 1'b0);

    // Back-pressure: result held while out_ready is low.
    bus.out_ready = 1'b0;
    issue(MD_DIV, 32'd1000, -32'sd7);
    wait_valid();
    repeat (5) begin
      @(posedge clk); #2;
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    wait_done();

    // Flush in the middle of an iteration; a simultaneous request is dropped.
    issue(MD_MUL, 32'd123, 32'd456);
    repeat (9) @(posedge clk);
    #2;
    flush = 1'b1;
    bus.op = MD_DIVU; bus.x = 32'd5; bus.y = 32'd0; bus.in_valid = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (40) @(posedge clk);
    #2;
    lit("post_flush", MD_MUL, 32'd11, 32'd13, 32'd143, 32'd0, 1'b0);

    // Asynchronous reset during an iteration.
    issue(MD_MULH, 32'h1234, 32'h10);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_lo", 64'(bus.result_lo), 64'd0);
    chk("arst_hi", 64'(bus.result_hi), 64'd0);
    chk("arst_dz", 64'(bus.div_zero), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    lit("post_rst", MD_DIVU, 32'd99, 32'd10, 32'd9, 32'd9, 1'b0);

    // Randomized operations with random back-pressure.
    for (int i = 0; i < 200; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      issue(o, rnd_opnd(), rnd_opnd());
      if (!bus.out_ready) begin
        wait_valid();
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
      end
      wait_done();
    end

    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
